mpd_ingest_ctrl: RTL and testbench
==================================

// Module: mpd_ingest_ctrl
// PURPOSE
//   Ingress controller: allocates a PRT slot per incoming packet, streams its words into the PRT, then queues a
//   (slot,len) descriptor for the classifier; packets longer than MAX_PKT_WORDS are drained, their slot invalidated, and counted.
// PARAMETERS
//   DATA_WIDTH     32   width of one packet word / PRT entry word
//   NUM_SLOTS      16   PRT slot count; SW=$clog2(NUM_SLOTS); descriptor queue depth = NUM_SLOTS
//   MAX_PKT_WORDS  64   max legal packet length in words; LW=$clog2(MAX_PKT_WORDS+1)
// PORTS
//   CLK                           in   1           clock, all state on rising edge
//   RST_N                         in   1           asynchronous active-low reset
//   in_valid                      in   1           ingress word valid
//   in_ready                      out  1           ingress word accepted when in_valid&&in_ready
//   in_data                       in   DATA_WIDTH  ingress word
//   in_last                       in   1           final word of packet
//   desc_valid                    out  1           descriptor available (queue not empty)
//   desc_ready                    in   1           classifier pops descriptor
//   desc_slot                     out  SW          PRT slot holding packet
//   desc_len                      out  LW          packet length in words (1..MAX_PKT_WORDS)
//   EN_start_writing_prt_entry    out  1           open PRT write; slot returned same cycle
//   RDY_start_writing_prt_entry   in   1           PRT can open a write
//   start_writing_prt_entry       in   SW          slot granted by PRT
//   EN_write_prt_entry            out  1           write one word to open slot
//   RDY_write_prt_entry           in   1           PRT accepts a word
//   write_prt_entry_data          out  DATA_WIDTH  word written (= in_data)
//   EN_finish_writing_prt_entry   out  1           close PRT write
//   RDY_finish_writing_prt_entry  in   1           PRT can close write
//   EN_invalidate_prt_entry       out  1           free slot of dropped packet
//   RDY_invalidate_prt_entry      in   1           PRT can invalidate
//   invalidate_prt_entry_slot     out  SW          slot to invalidate (= slot_q)
//   is_prt_slot_free              in   1           PRT has at least one free slot
//   RDY_is_prt_slot_free          in   1           is_prt_slot_free valid
//   drop_count                    out  16          saturating count of oversize drops
// BEHAVIOUR
//   Reset: state=IDLE, slot_q=0, len_q=0, queue empty, drop_count=0; all EN_* =0, in_ready=0, desc_valid=0, desc_slot/len=0.
//   Every EN_* is combinational from state and asserted only while its RDY_* is high; never two EN_* in one cycle.
//   IDLE: in_ready=0. Start when in_valid && is_prt_slot_free && RDY_is_prt_slot_free && RDY_start_writing && !q_full:
//     EN_start_writing=1 for exactly that cycle, slot_q<=start_writing_prt_entry, len_q<=0, ->WRITE. Else hold.
//   WRITE: in_ready=RDY_write_prt_entry; EN_write=in_valid&&in_ready; write_prt_entry_data=in_data; len_q++ per beat.
//     Accepted beat with in_last -> FINISH (packet of exactly MAX_PKT_WORDS words is legal).
//     Accepted beat with !in_last and len_q+1==MAX_PKT_WORDS -> DRAIN.
//   FINISH: in_ready=0; EN_finish=RDY_finish; on EN_finish push {slot_q,len_q} into queue, ->IDLE (new start next cycle earliest).
//   DRAIN: in_ready=1, EN_write=0, words discarded; accepted in_last -> INVAL.
//   INVAL: in_ready=0; EN_invalidate=RDY_invalidate with slot_q; on fire drop_count++ (saturate at 16'hFFFF), ->IDLE.
//   Queue: FIFO of NUM_SLOTS {slot,len}; desc_* show head; pop on desc_valid&&desc_ready; push+pop same cycle allowed,
//     count unchanged; push when full impossible (IDLE gating); wrap-around of pointers mod NUM_SLOTS.
//   Reset mid-packet: packet abandoned, no descriptor, no invalidate; PRT shares RST_N and clears itself.
// TESTING
//   3-word pkt A,B,C, all RDY=1, slot grant 5 -> 1-cycle EN_start, 3 EN_write A,B,C, EN_finish, desc slot=5 len=3.
//   MAX_PKT_WORDS=8, 10-word pkt -> 8 EN_write, 2 beats drained (in_ready=1, no EN_write), EN_invalidate slot_q, drop_count=1, no desc.
//   MAX_PKT_WORDS=8, 8-word pkt with in_last on beat 8 -> normal EN_finish, desc len=8, drop_count unchanged.
//   is_prt_slot_free=0 for 20 cycles with in_valid=1 -> in_ready=0, no EN_*; raise -> start next cycle; RDY_write toggled -> EN_write only when RDY.
//   desc_ready=0, 16 packets -> queue full blocks IDLE start; one pop -> 17th proceeds; assert RST_N low mid-WRITE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mpd_ingest_ctrl_if.sv
// Ingress, descriptor and PRT method signals for mpd_ingest_ctrl.
// The master modport is the controller; the slave modport is its environment (source, classifier, PRT).
interface mpd_ingest_ctrl_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_SLOTS     = 16,
    parameter int unsigned MAX_PKT_WORDS = 64
);
    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam int unsigned LW = $clog2(MAX_PKT_WORDS + 1);

    // ingress stream
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;

    // descriptor queue towards the classifier
    logic                  desc_valid;
    logic                  desc_ready;
    logic [SW-1:0]         desc_slot;
    logic [LW-1:0]         desc_len;

    // PRT methods
    logic                  EN_start_writing_prt_entry;
    logic                  RDY_start_writing_prt_entry;
    logic [SW-1:0]         start_writing_prt_entry;
    logic                  EN_write_prt_entry;
    logic                  RDY_write_prt_entry;
    logic [DATA_WIDTH-1:0] write_prt_entry_data;
    logic                  EN_finish_writing_prt_entry;
    logic                  RDY_finish_writing_prt_entry;
    logic                  EN_invalidate_prt_entry;
    logic                  RDY_invalidate_prt_entry;
    logic [SW-1:0]         invalidate_prt_entry_slot;
    logic                  is_prt_slot_free;
    logic                  RDY_is_prt_slot_free;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready,
        output desc_valid, desc_slot, desc_len,
        input  desc_ready,
        output EN_start_writing_prt_entry,
        input  RDY_start_writing_prt_entry, start_writing_prt_entry,
        output EN_write_prt_entry, write_prt_entry_data,
        input  RDY_write_prt_entry,
        output EN_finish_writing_prt_entry,
        input  RDY_finish_writing_prt_entry,
        output EN_invalidate_prt_entry, invalidate_prt_entry_slot,
        input  RDY_invalidate_prt_entry,
        input  is_prt_slot_free, RDY_is_prt_slot_free
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  desc_valid, desc_slot, desc_len,
        output desc_ready,
        input  EN_start_writing_prt_entry,
        output RDY_start_writing_prt_entry, start_writing_prt_entry,
        input  EN_write_prt_entry, write_prt_entry_data,
        output RDY_write_prt_entry,
        input  EN_finish_writing_prt_entry,
        output RDY_finish_writing_prt_entry,
        input  EN_invalidate_prt_entry, invalidate_prt_entry_slot,
        output RDY_invalidate_prt_entry,
        output is_prt_slot_free, RDY_is_prt_slot_free
    );
endinterface

// File: rtl/mpd_ingest_ctrl.sv
// Ingress controller: opens a PRT slot per packet, streams words into it and queues a (slot,len)
// descriptor; oversize packets are drained, their slot invalidated and the drop counted.
module mpd_ingest_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_SLOTS     = 16,
    parameter int unsigned MAX_PKT_WORDS = 64
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    mpd_ingest_ctrl_if.master      bus,
    output logic [15:0]            drop_count
);
    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam int unsigned LW = $clog2(MAX_PKT_WORDS + 1);

    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_PKT_WORDS);
    localparam logic [SW-1:0] LAST_PTR = SW'(NUM_SLOTS - 1);
    localparam logic [SW:0]   Q_DEPTH  = (SW + 1)'(NUM_SLOTS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_FINISH = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_INVAL  = 3'd4;

    logic [2:0]    state_q;
    logic [SW-1:0] slot_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_next;

    logic [SW-1:0] q_slot_mem [NUM_SLOTS];
    logic [LW-1:0] q_len_mem  [NUM_SLOTS];
    logic [SW-1:0] wr_ptr;
    logic [SW-1:0] rd_ptr;
    logic [SW:0]   q_count;
    logic          q_full;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;

    logic          start_ok;
    logic          en_start;
    logic          en_write;
    logic          en_finish;
    logic          en_inval;
    logic          ready;
    logic          beat;

    function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + SW'(1);
    endfunction

    assign q_full   = (q_count == Q_DEPTH);
    assign q_empty  = (q_count == '0);
    assign len_next = len_q + LW'(1);

    assign start_ok = bus.in_valid && bus.is_prt_slot_free && bus.RDY_is_prt_slot_free &&
                      bus.RDY_start_writing_prt_entry && !q_full;

    // Every enable is decoded from the current state, so at most one PRT method fires per cycle.
    always_comb begin
        en_start  = 1'b0;
        en_write  = 1'b0;
        en_finish = 1'b0;
        en_inval  = 1'b0;
        ready     = 1'b0;
        case (state_q)
            S_IDLE: begin
                en_start = start_ok;
            end
            S_WRITE: begin
                ready    = bus.RDY_write_prt_entry;
                en_write = bus.in_valid && bus.RDY_write_prt_entry;
            end
            S_FINISH: begin
                en_finish = bus.RDY_finish_writing_prt_entry;
            end
            S_DRAIN: begin
                ready = 1'b1;
            end
            S_INVAL: begin
                en_inval = bus.RDY_invalidate_prt_entry;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign beat = bus.in_valid && ready;

    assign bus.in_ready                    = ready;
    assign bus.EN_start_writing_prt_entry  = en_start;
    assign bus.EN_write_prt_entry          = en_write;
    assign bus.write_prt_entry_data        = bus.in_data;
    assign bus.EN_finish_writing_prt_entry = en_finish;
    assign bus.EN_invalidate_prt_entry     = en_inval;
    assign bus.invalidate_prt_entry_slot   = slot_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        slot_q  <= bus.start_writing_prt_entry;
                        len_q   <= '0;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (beat) begin
                        len_q <= len_next;
                        // a last word landing exactly on MAX_LEN is still a legal packet
                        if (bus.in_last) begin
                            state_q <= S_FINISH;
                        end else if (len_next == MAX_LEN) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_FINISH: begin
                    if (en_finish) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (beat && bus.in_last) begin
                        state_q <= S_INVAL;
                    end
                end
                S_INVAL: begin
                    if (en_inval) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_count <= '0;
        end else if (en_inval && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Descriptor FIFO; IDLE refuses to open a packet while it is full, so a push never overflows.
    assign q_push = en_finish;
    assign q_pop  = !q_empty && bus.desc_ready;

    always_ff @(posedge CLK) begin
        if (q_push) begin
            q_slot_mem[wr_ptr] <= slot_q;
            q_len_mem[wr_ptr]  <= len_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (q_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (q_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (q_push && !q_pop) begin
                q_count <= q_count + (SW + 1)'(1);
            end else if (q_pop && !q_push) begin
                q_count <= q_count - (SW + 1)'(1);
            end
        end
    end

    assign bus.desc_valid = !q_empty;
    assign bus.desc_slot  = q_empty ? '0 : q_slot_mem[rd_ptr];
    assign bus.desc_len   = q_empty ? '0 : q_len_mem[rd_ptr];

endmodule

// File: tb/tb_mpd_ingest_ctrl.sv
// Bench for mpd_ingest_ctrl: directed scenarios plus randomized packets, scored against a
// packet-level model (expected written words, per-packet outcome, descriptor FIFO, drop total).
`timescale 1ns/1ps
module tb_mpd_ingest_ctrl;
    localparam int unsigned DW   = 32;
    localparam int unsigned NS   = 16;
    localparam int unsigned MAXW = 8;
    localparam int unsigned SW   = 4;
    localparam int unsigned LW   = 4;

    typedef struct packed {
        logic [SW-1:0] slot;
        logic [LW-1:0] len;
    } desc_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    mpd_ingest_ctrl_if #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_PKT_WORDS(MAXW)) bus ();

    mpd_ingest_ctrl #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_PKT_WORDS(MAXW)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .bus        (bus),
        .drop_count (drop_count)
    );

    always #5 CLK = ~CLK;

    // packet-level reference state
    logic [DW-1:0] pkt_words [$];
    logic [DW-1:0] wq [$];
    int            pq_len [$];
    bit            pq_drop [$];
    desc_t         dq [$];
    int            exp_drops = 0;
    bit            in_pkt = 0;
    logic [SW-1:0] cur_slot = '0;
    int n_start = 0, n_write = 0, n_finish = 0, n_inval = 0, n_drain = 0;
    bit rand_rdy = 0, rand_wr = 0, rand_desc = 0, gaps = 0;
    int en_sum;

    function automatic void model_add_pkt(input int n);
        pkt_words.delete();
        for (int i = 0; i < n; i++) begin
            pkt_words.push_back($urandom());
            if (i < int'(MAXW)) wq.push_back(pkt_words[i]);
        end
        pq_drop.push_back(n > int'(MAXW));
        pq_len.push_back((n > int'(MAXW)) ? 0 : n);
    endfunction

    function automatic void model_flush();
        wq.delete();
        pq_len.delete();
        pq_drop.delete();
        dq.delete();
        exp_drops = 0;
        in_pkt = 0;
    endfunction

    function automatic logic [33:0] out_vec();
        return {bus.in_ready, bus.desc_valid, bus.desc_slot, bus.desc_len,
                bus.EN_start_writing_prt_entry, bus.EN_write_prt_entry,
                bus.EN_finish_writing_prt_entry, bus.EN_invalidate_prt_entry,
                bus.invalidate_prt_entry_slot, drop_count};
    endfunction

    // scoreboard: observes every PRT method and descriptor pop mid-cycle
    always @(negedge CLK) begin
        if (RST_N) begin
            en_sum = int'(bus.EN_start_writing_prt_entry) + int'(bus.EN_write_prt_entry) +
                     int'(bus.EN_finish_writing_prt_entry) + int'(bus.EN_invalidate_prt_entry);
            checks++;
            if (en_sum > 1 ||
                (bus.EN_start_writing_prt_entry && !bus.RDY_start_writing_prt_entry) ||
                (bus.EN_write_prt_entry && !(bus.RDY_write_prt_entry && bus.in_valid && bus.in_ready)) ||
                (bus.EN_finish_writing_prt_entry && !bus.RDY_finish_writing_prt_entry) ||
                (bus.EN_invalidate_prt_entry && !bus.RDY_invalidate_prt_entry)) begin
                errors++;
                $display("FAIL en_rules t=%0t en_sum=%0d got EN=%b", $time, en_sum,
                         {bus.EN_start_writing_prt_entry, bus.EN_write_prt_entry,
                          bus.EN_finish_writing_prt_entry, bus.EN_invalidate_prt_entry});
            end
            checks++;
            if (bus.desc_valid !== (dq.size() != 0)) begin
                errors++;
                $display("FAIL desc_valid t=%0t got %b exp %b", $time, bus.desc_valid, dq.size() != 0);
            end
            if (bus.desc_valid && dq.size() != 0) begin
                checks++;
                if (desc_t'({bus.desc_slot, bus.desc_len}) !== dq[0]) begin
                    errors++;
                    $display("FAIL desc_head t=%0t got slot=%0d len=%0d exp slot=%0d len=%0d",
                             $time, bus.desc_slot, bus.desc_len, dq[0].slot, dq[0].len);
                end
                if (bus.desc_ready) void'(dq.pop_front());
            end
            checks++;
            if (drop_count !== 16'(exp_drops)) begin
                errors++;
                $display("FAIL drop_count t=%0t got %0d exp %0d", $time, drop_count, exp_drops);
            end
            if (bus.EN_start_writing_prt_entry) begin
                n_start++;
                checks++;
                if (in_pkt || pq_drop.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected t=%0t got start exp none (in_pkt=%0d)", $time, in_pkt);
                end
                in_pkt = 1;
                cur_slot = bus.start_writing_prt_entry;
            end
            if (bus.EN_write_prt_entry) begin
                n_write++;
                checks++;
                if (!in_pkt || wq.size() == 0 || bus.write_prt_entry_data !== wq[0]) begin
                    errors++;
                    $display("FAIL write_data t=%0t got %h exp %h", $time, bus.write_prt_entry_data,
                             (wq.size() != 0) ? wq[0] : '0);
                end
                if (wq.size() != 0) void'(wq.pop_front());
            end else if (bus.in_valid && bus.in_ready) begin
                n_drain++;
            end
            if (bus.EN_finish_writing_prt_entry) begin
                n_finish++;
                checks++;
                if (!in_pkt || pq_drop.size() == 0 || pq_drop[0]) begin
                    errors++;
                    $display("FAIL finish_unexpected t=%0t got finish exp drop/none", $time);
                end else begin
                    dq.push_back('{slot: cur_slot, len: LW'(pq_len[0])});
                end
                if (pq_drop.size() != 0) begin
                    void'(pq_drop.pop_front());
                    void'(pq_len.pop_front());
                end
                in_pkt = 0;
            end
            if (bus.EN_invalidate_prt_entry) begin
                n_inval++;
                checks++;
                if (!in_pkt || pq_drop.size() == 0 || !pq_drop[0] ||
                    bus.invalidate_prt_entry_slot !== cur_slot) begin
                    errors++;
                    $display("FAIL invalidate t=%0t got slot=%0d exp slot=%0d", $time,
                             bus.invalidate_prt_entry_slot, cur_slot);
                end
                if (pq_drop.size() != 0) begin
                    void'(pq_drop.pop_front());
                    void'(pq_len.pop_front());
                end
                exp_drops++;
                in_pkt = 0;
            end
        end
    end

    // background randomisation of PRT readiness, slot grants and classifier pops
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_rdy) begin
                bus.RDY_start_writing_prt_entry  = ($urandom_range(0, 3) != 0);
                bus.RDY_write_prt_entry          = ($urandom_range(0, 3) != 0);
                bus.RDY_finish_writing_prt_entry = ($urandom_range(0, 1) != 0);
                bus.RDY_invalidate_prt_entry     = ($urandom_range(0, 1) != 0);
                bus.is_prt_slot_free             = ($urandom_range(0, 7) != 0);
                bus.RDY_is_prt_slot_free         = ($urandom_range(0, 7) != 0);
                bus.start_writing_prt_entry      = SW'($urandom_range(0, NS - 1));
            end
            if (rand_wr) bus.RDY_write_prt_entry = ($urandom_range(0, 1) != 0);
            if (rand_desc) bus.desc_ready = ($urandom_range(0, 1) != 0);
        end
    end

    task automatic all_rdy();
        bus.RDY_start_writing_prt_entry  = 1;
        bus.RDY_write_prt_entry          = 1;
        bus.RDY_finish_writing_prt_entry = 1;
        bus.RDY_invalidate_prt_entry     = 1;
        bus.is_prt_slot_free             = 1;
        bus.RDY_is_prt_slot_free         = 1;
    endtask

    task automatic drive_words(input int n, input int upto);
        bit acc;
        int w;
        for (int i = 0; i < upto; i++) begin
            acc = 0;
            w = 0;
            bus.in_valid = 1;
            bus.in_data  = pkt_words[i];
            bus.in_last  = (i == n - 1);
            while (!acc && w < 300) begin
                @(negedge CLK);
                acc = bus.in_ready;
                @(posedge CLK);
                #1;
                w++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout word %0d got in_ready=0 exp 1 within 300 cycles", i);
                bus.in_valid = 0;
                return;
            end
            if (gaps && i < upto - 1 && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 0;
                repeat ($urandom_range(1, 2)) @(posedge CLK);
                #1;
            end
        end
        if (upto == n) begin
            bus.in_valid = 0;
            bus.in_last  = 0;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((in_pkt || pq_drop.size() != 0) && w < 600) begin
            @(posedge CLK);
            #2;
            w++;
        end
        checks++;
        if (in_pkt || pq_drop.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout got %0d pending packets exp 0", pq_drop.size());
        end
    endtask

    task automatic drain_desc();
        int w = 0;
        bus.desc_ready = 1;
        while (dq.size() != 0 && w < 200) begin
            @(posedge CLK);
            #2;
            w++;
        end
        bus.desc_ready = 0;
        checks++;
        if (dq.size() != 0 || bus.desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout got %0d queued desc_valid=%b exp 0", dq.size(), bus.desc_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #2;
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL reset_held got %h exp 0", out_vec());
        end
        RST_N = 1;
        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL reset_idle got %h exp 0", out_vec());
        end
    endtask

    task automatic test_basic();
        int s0 = n_start, w0 = n_write, f0 = n_finish, w;
        all_rdy();
        bus.start_writing_prt_entry = SW'(5);
        bus.desc_ready = 0;
        model_add_pkt(3);
        drive_words(3, 3);
        wait_idle();
        checks++;
        if (n_start - s0 != 1 || n_write - w0 != 3 || n_finish - f0 != 1) begin
            errors++;
            $display("FAIL basic_counts got start=%0d write=%0d finish=%0d exp 1 3 1",
                     n_start - s0, n_write - w0, n_finish - f0);
        end
        w = 0;
        while (!bus.desc_valid && w < 20) begin
            @(posedge CLK);
            #2;
            w++;
        end
        checks++;
        if (bus.desc_valid !== 1'b1 || bus.desc_slot !== SW'(5) || bus.desc_len !== LW'(3)) begin
            errors++;
            $display("FAIL basic_desc got v=%b slot=%0d len=%0d exp v=1 slot=5 len=3",
                     bus.desc_valid, bus.desc_slot, bus.desc_len);
        end
        drain_desc();
    endtask

    task automatic test_oversize();
        int w0 = n_write, d0 = n_drain, i0 = n_inval, f0 = n_finish, x0 = exp_drops;
        all_rdy();
        bus.start_writing_prt_entry = SW'(9);
        model_add_pkt(10);
        drive_words(10, 10);
        wait_idle();
        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if (n_write - w0 != 8 || n_drain - d0 != 2 || n_inval - i0 != 1 || n_finish != f0) begin
            errors++;
            $display("FAIL oversize_counts got write=%0d drain=%0d inval=%0d finish=%0d exp 8 2 1 0",
                     n_write - w0, n_drain - d0, n_inval - i0, n_finish - f0);
        end
        checks++;
        if (drop_count !== 16'(x0 + 1) || bus.desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL oversize_drop got drops=%0d desc_valid=%b exp drops=%0d desc_valid=0",
                     drop_count, bus.desc_valid, x0 + 1);
        end
    endtask

    task automatic test_exact_max();
        int w0 = n_write, f0 = n_finish, x0 = exp_drops, w = 0;
        all_rdy();
        bus.start_writing_prt_entry = SW'(2);
        model_add_pkt(8);
        drive_words(8, 8);
        wait_idle();
        while (!bus.desc_valid && w < 20) begin
            @(posedge CLK);
            #2;
            w++;
        end
        checks++;
        if (n_write - w0 != 8 || n_finish - f0 != 1 || bus.desc_len !== LW'(8) ||
            bus.desc_slot !== SW'(2) || drop_count !== 16'(x0)) begin
            errors++;
            $display("FAIL exact_max got write=%0d finish=%0d len=%0d slot=%0d drops=%0d exp 8 1 8 2 %0d",
                     n_write - w0, n_finish - f0, bus.desc_len, bus.desc_slot, drop_count, x0);
        end
        drain_desc();
    endtask

    task automatic test_slot_free();
        int w0 = n_write;
        bit bad = 0;
        all_rdy();
        bus.is_prt_slot_free = 0;
        model_add_pkt(5);
        bus.in_valid = 1;
        bus.in_data  = pkt_words[0];
        bus.in_last  = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK);
            #2;
            if (bus.in_ready !== 1'b0 || bus.EN_start_writing_prt_entry !== 1'b0 ||
                bus.EN_write_prt_entry !== 1'b0 || bus.EN_finish_writing_prt_entry !== 1'b0 ||
                bus.EN_invalidate_prt_entry !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL slot_busy got activity while no slot free exp none");
        end
        bus.is_prt_slot_free = 1;
        #1;
        checks++;
        if (bus.EN_start_writing_prt_entry !== 1'b1) begin
            errors++;
            $display("FAIL slot_free_start got %b exp 1", bus.EN_start_writing_prt_entry);
        end
        rand_wr = 1;
        drive_words(5, 5);
        wait_idle();
        rand_wr = 0;
        bus.RDY_write_prt_entry = 1;
        checks++;
        if (n_write - w0 != 5) begin
            errors++;
            $display("FAIL slot_free_writes got %0d exp 5", n_write - w0);
        end
        drain_desc();
    endtask

    task automatic test_queue_full();
        bit bad = 0;
        all_rdy();
        bus.desc_ready = 0;
        for (int p = 0; p < int'(NS); p++) begin
            bus.start_writing_prt_entry = SW'(p);
            model_add_pkt(int'($urandom_range(1, 3)));
            drive_words(pkt_words.size(), pkt_words.size());
            wait_idle();
        end
        checks++;
        if (dq.size() != int'(NS) || bus.desc_valid !== 1'b1) begin
            errors++;
            $display("FAIL queue_fill got model=%0d desc_valid=%b exp %0d 1", dq.size(), bus.desc_valid, NS);
        end
        model_add_pkt(2);
        bus.in_valid = 1;
        bus.in_data  = pkt_words[0];
        bus.in_last  = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK);
            #2;
            if (bus.EN_start_writing_prt_entry !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL queue_full_block got EN_start=1 exp 0 while full");
        end
        bus.desc_ready = 1;
        @(posedge CLK);
        #2;
        bus.desc_ready = 0;
        #1;
        checks++;
        if (bus.EN_start_writing_prt_entry !== 1'b1) begin
            errors++;
            $display("FAIL queue_pop_start got %b exp 1", bus.EN_start_writing_prt_entry);
        end
        drive_words(2, 2);
        wait_idle();
        drain_desc();
    endtask

    task automatic test_random();
        int i0 = n_inval, f0 = n_finish, ndrop = 0, nok = 0, len;
        rand_rdy = 1;
        rand_desc = 1;
        gaps = 1;
        for (int p = 0; p < 40; p++) begin
            len = int'($urandom_range(1, 12));
            if (len > int'(MAXW)) ndrop++; else nok++;
            model_add_pkt(len);
            drive_words(len, len);
        end
        wait_idle();
        rand_rdy = 0;
        rand_desc = 0;
        gaps = 0;
        all_rdy();
        drain_desc();
        checks++;
        if (n_inval - i0 != ndrop || n_finish - f0 != nok || wq.size() != 0) begin
            errors++;
            $display("FAIL random_totals got inval=%0d finish=%0d leftover=%0d exp %0d %0d 0",
                     n_inval - i0, n_finish - f0, wq.size(), ndrop, nok);
        end
    endtask

    task automatic test_reset_mid();
        all_rdy();
        bus.desc_ready = 0;
        model_add_pkt(3);
        drive_words(3, 3);
        wait_idle();
        model_add_pkt(6);
        drive_words(6, 2);
        bus.in_valid = 0;
        RST_N = 0;
        model_flush();
        #1;
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid_async got %h exp 0", out_vec());
        end
        @(posedge CLK);
        #2;
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid_next got %h exp 0", out_vec());
        end
        RST_N = 1;
        bus.start_writing_prt_entry = SW'(11);
        model_add_pkt(2);
        drive_words(2, 2);
        wait_idle();
        drain_desc();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout exp completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        bus.in_valid = 0;
        bus.in_data  = '0;
        bus.in_last  = 0;
        bus.desc_ready = 0;
        bus.start_writing_prt_entry = '0;
        all_rdy();
        test_reset();
        test_basic();
        test_oversize();
        test_exact_max();
        test_slot_free();
        test_queue_full();
        test_random();
        test_reset_mid();
        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
